// File: rtl/cheri_err_mon_pkg.sv
// Shared types and constants for the CHERI error monitor.
package cheri_err_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } chan_state_e;

  localparam int unsigned NumCheriErr = 9;

  localparam int unsigned ERR_BOUNDS                 = 0;
  localparam int unsigned ERR_TAG                    = 1;
  localparam int unsigned ERR_SEAL                   = 2;
  localparam int unsigned ERR_PERMIT_EXECUTE         = 3;
  localparam int unsigned ERR_PERMIT_LOAD            = 4;
  localparam int unsigned ERR_PERMIT_STORE           = 5;
  localparam int unsigned ERR_PERMIT_STORE_CAP       = 6;
  localparam int unsigned ERR_PERMIT_STORE_LOCAL_CAP = 7;
  localparam int unsigned ERR_PERMIT_ACC_SYS_REGS    = 8;

endpackage

// File: rtl/cheri_err_mon_chan.sv
// One error channel: burst-collapsing FSM, gap timer, saturating counter and sticky flag.
module cheri_err_mon_chan
  import cheri_err_mon_pkg::*;
#(
  parameter int unsigned CountWidth = 16,
  parameter int unsigned GapCycles  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  err_i,
  output logic                  event_o,
  output logic                  errored_o,
  output logic                  new_err_o,
  output logic [CountWidth-1:0] cnt_o
);

  localparam logic [7:0] GapLoad = 8'(GapCycles - 1);

  chan_state_e           state_q;
  logic [7:0]            gap_q;
  logic [CountWidth-1:0] cnt_q;
  logic                  errored_q;
  logic                  new_err_q;

  function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] v);
    return (&v) ? v : v + CountWidth'(1);
  endfunction

  // Only a rising burst seen from IDLE is a new event; the clear cycle discards input.
  assign event_o = (state_q == IDLE) && err_i && !clear_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      cnt_q     <= '0;
      errored_q <= 1'b0;
      new_err_q <= 1'b0;
    end else if (clear_i) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      cnt_q     <= '0;
      errored_q <= 1'b0;
      new_err_q <= 1'b0;
    end else begin
      new_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (err_i) begin
            state_q   <= ACTIVE;
            cnt_q     <= sat_inc(cnt_q);
            errored_q <= 1'b1;
            new_err_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!err_i) begin
            state_q <= GAP;
            gap_q   <= GapLoad;
          end
        end
        GAP: begin
          if (err_i) begin
            state_q <= ACTIVE;
          end else if (gap_q == 8'd0) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign errored_o = errored_q;
  assign new_err_o = new_err_q;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/cheri_err_monitor.sv
// CHERI error monitor top: per-channel event counting, first-error capture and counter read mux.
// Define CHERI_ERR_MON_TIMESTAMP_EN to add the free-running time counter and first-error timestamp.
module cheri_err_monitor
  import cheri_err_mon_pkg::*;
#(
  parameter int unsigned ErrWidth   = NumCheriErr,
  parameter int unsigned CountWidth = 16,
  parameter int unsigned GapCycles  = 16,
  parameter int unsigned TimeWidth  = 32,
  localparam int unsigned IdxWidth  = $clog2(ErrWidth)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [ErrWidth-1:0]   err_i,
  output logic [ErrWidth-1:0]   errored_o,
  output logic [ErrWidth-1:0]   new_err_o,
  output logic                  any_err_o,
  output logic                  first_valid_o,
  output logic [IdxWidth-1:0]   first_idx_o,
  output logic [TimeWidth-1:0]  first_time_o,
  input  logic [IdxWidth-1:0]   cnt_idx_i,
  output logic [CountWidth-1:0] cnt_o
);

  logic [ErrWidth-1:0]   event_w;
  logic [CountWidth-1:0] cnt_w [ErrWidth];

  for (genvar g = 0; g < ErrWidth; g++) begin : g_chan
    cheri_err_mon_chan #(
      .CountWidth(CountWidth),
      .GapCycles (GapCycles)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .err_i    (err_i[g]),
      .event_o  (event_w[g]),
      .errored_o(errored_o[g]),
      .new_err_o(new_err_o[g]),
      .cnt_o    (cnt_w[g])
    );
  end

  assign any_err_o = |errored_o;

  function automatic logic [IdxWidth-1:0] lowest_idx(input logic [ErrWidth-1:0] v);
    logic [IdxWidth-1:0] r;
    logic                found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < ErrWidth; i++) begin
      if (v[i] && !found) begin
        r     = IdxWidth'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  logic                first_valid_q;
  logic [IdxWidth-1:0] first_idx_q;
  logic                capture_d;

  assign capture_d = !first_valid_q && (|event_w);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      first_valid_q <= 1'b0;
      first_idx_q   <= '0;
    end else if (clear_i) begin
      first_valid_q <= 1'b0;
      first_idx_q   <= '0;
    end else if (capture_d) begin
      first_valid_q <= 1'b1;
      first_idx_q   <= lowest_idx(event_w);
    end
  end

  assign first_valid_o = first_valid_q;
  assign first_idx_o   = first_idx_q;

`ifdef CHERI_ERR_MON_TIMESTAMP_EN
  logic [TimeWidth-1:0] time_q;
  logic [TimeWidth-1:0] first_time_q;

  // The time counter ignores clear so timestamps stay comparable across clears.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      time_q       <= '0;
      first_time_q <= '0;
    end else begin
      time_q <= time_q + TimeWidth'(1);
      if (clear_i) begin
        first_time_q <= '0;
      end else if (capture_d) begin
        first_time_q <= time_q;
      end
    end
  end

  assign first_time_o = first_time_q;
`else
  assign first_time_o = '0;
`endif

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < ErrWidth; i++) begin
      if (cnt_idx_i == IdxWidth'(i)) begin
        cnt_o = cnt_w[i];
      end
    end
  end

endmodule
